// File: rtl/vcss_cdc_fifo_dst_channel.sv
// -----------------------------------------------------------------------------
// vcss_cdc_fifo_dst_channel
//
// Destination (read) half of one gray-pointer asynchronous FIFO channel of the
// vcss AXI CDC link. It lives in the vcss clock domain. It synchronises the
// source's gray write pointer and reads entries straight out of the storage
// array held by the source half. Entries are presented as a valid/ready
// stream, and a registered gray read pointer is returned to the source half.
//
// Parameters
//   WIDTH        payload bits per entry
//   LOG_DEPTH    log2 of FIFO depth; pointers are LOG_DEPTH+1 bits
//   SYNC_STAGES  synchroniser flops on the incoming write pointer (>= 2)
//
// Ports
//   clk_i                destination-domain clock
//   rst_ni               asynchronous active-low reset
//   async_data_i         source storage array, entry n = [n*WIDTH +: WIDTH]
//   async_wr_ptr_gray_i  source write pointer (gray, source clock domain)
//   async_rd_ptr_gray_o  read pointer (gray), straight from a flop
//   dst_data_o           head entry payload (meaningful while dst_valid_o)
//   dst_valid_o          head entry available
//   dst_ready_i          consumer accepts head entry
//   dst_level_o          occupancy seen by this side
//
// Optional feature: define VCSS_CDC_DST_LEVEL_EN to build the registered
// occupancy output. Without it, dst_level_o is tied to zero and no
// gray-to-binary or subtractor logic is built.
// -----------------------------------------------------------------------------
module vcss_cdc_fifo_dst_channel #(
  parameter int WIDTH       = 71,
  parameter int LOG_DEPTH   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [(2**LOG_DEPTH)*WIDTH-1:0] async_data_i,
  input  logic [LOG_DEPTH:0]              async_wr_ptr_gray_i,
  output logic [LOG_DEPTH:0]              async_rd_ptr_gray_o,
  output logic [WIDTH-1:0]                dst_data_o,
  output logic                            dst_valid_o,
  input  logic                            dst_ready_i,
  output logic [LOG_DEPTH:0]              dst_level_o
);

  localparam int DEPTH = 2**LOG_DEPTH;
  localparam int PW    = LOG_DEPTH + 1;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PW-1:0]    wr_gray_sync [SYNC_STAGES];
  logic [PW-1:0]    wr_gray_s;
  logic [PW-1:0]    rd_ptr_bin;
  logic [PW-1:0]    rd_ptr_bin_next;
  logic             pop;
  logic [WIDTH-1:0] entries [DEPTH];

  // ---- synchroniser: the raw cross-domain pointer lands directly on flop 0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) wr_gray_sync[i] <= '0;
    end else begin
      wr_gray_sync[0] <= async_wr_ptr_gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) wr_gray_sync[i] <= wr_gray_sync[i-1];
    end
  end

  assign wr_gray_s = wr_gray_sync[SYNC_STAGES-1];

  // Both operands are registers, so valid never depends on ready.
  assign dst_valid_o     = (wr_gray_s != async_rd_ptr_gray_o);
  assign pop             = dst_valid_o & dst_ready_i;
  assign rd_ptr_bin_next = pop ? (rd_ptr_bin + PW'(1)) : rd_ptr_bin;

  // ---- read pointer: binary copy for addressing, gray copy for the source half
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_bin          <= '0;
      async_rd_ptr_gray_o <= '0;
    end else if (pop) begin
      rd_ptr_bin          <= rd_ptr_bin_next;
      async_rd_ptr_gray_o <= bin2gray(rd_ptr_bin_next);
    end
  end

  for (genvar n = 0; n < DEPTH; n++) begin : g_entry
    assign entries[n] = async_data_i[n*WIDTH +: WIDTH];
  end

  // The MSB of the pointer only separates full from empty; the low bits address.
  assign dst_data_o = entries[rd_ptr_bin[LOG_DEPTH-1:0]];

`ifdef VCSS_CDC_DST_LEVEL_EN
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // ---- occupancy: uses the post-pop pointer so it reflects this cycle's read
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) dst_level_o <= '0;
    else         dst_level_o <= gray2bin(wr_gray_s) - rd_ptr_bin_next;
  end
`else
  assign dst_level_o = '0;
`endif

endmodule

// File: tb/tb_vcss_cdc_fifo_dst_channel.sv
// -----------------------------------------------------------------------------
// tb_vcss_cdc_fifo_dst_channel
//
// Bench for the destination half of the vcss CDC FIFO channel. The bench plays
// the source half: it holds the storage array and a write count. It keeps a
// behavioural model built from absolute entry counts: a per-edge history of
// the write count, which gives the synchronised count, a read count, and a
// queue of every pushed payload. Every cycle, one compare step checks valid,
// the gray read pointer, the level and the head data against that model.
// Directed scenarios add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_vcss_cdc_fifo_dst_channel;

  localparam int W  = 71;
  localparam int LD = 1;
  localparam int S  = 2;
  localparam int D  = 2**LD;
  localparam int PW = LD + 1;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic [D*W-1:0] async_data;
  logic [PW-1:0]  wr_gray;
  logic [PW-1:0]  rd_gray;
  logic [W-1:0]   data;
  logic           valid;
  logic           ready;
  logic [PW-1:0]  level;

  always #5 clk = ~clk;

  vcss_cdc_fifo_dst_channel #(
    .WIDTH      (W),
    .LOG_DEPTH  (LD),
    .SYNC_STAGES(S)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .async_data_i       (async_data),
    .async_wr_ptr_gray_i(wr_gray),
    .async_rd_ptr_gray_o(rd_gray),
    .dst_data_o         (data),
    .dst_valid_o        (valid),
    .dst_ready_i        (ready),
    .dst_level_o        (level)
  );

  int errors = 0;
  int checks = 0;

  // model state (absolute counts, never wrapped)
  int         wr_cnt;
  int         rd_m;
  int         level_m;
  bit         m_valid;
  int         hist[$];
  logic [W-1:0] pushed[$];

  logic [PW-1:0] gt [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic logic [PW-1:0] g(input int n);
    logic [PW-1:0] b;
    b = n[PW-1:0];
    return b ^ (b >> 1);
  endfunction

  // write count as seen through the synchroniser
  function automatic int synced();
    if (hist.size() < S) return 0;
    return hist[hist.size() - S];
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rd_m    = 0;
    level_m = 0;
    m_valid = 1'b0;
    hist.delete();
  endtask

  task automatic compare();
    chk("valid", W'(valid), W'(m_valid));
    chk("rd_gray", W'(rd_gray), W'(g(rd_m)));
`ifdef VCSS_CDC_DST_LEVEL_EN
    chk("level", W'(level), W'(level_m));
`else
    chk("level", W'(level), W'(0));
`endif
    if (m_valid && rd_m < pushed.size()) chk("data", data, pushed[rd_m]);
  endtask

  // one clock: model advances on the rising edge, outputs are compared on the falling edge
  task automatic cycle();
    bit pop;
    int sb;
    @(posedge clk);
    if (!rst_ni) begin
      model_reset();
    end else begin
      pop = m_valid && ready;
      sb  = synced();
      if (pop) rd_m++;
      level_m = sb - rd_m;
      hist.push_back(wr_cnt);
      m_valid = (synced() != rd_m);
    end
    @(negedge clk);
    compare();
  endtask

  task automatic push(input logic [W-1:0] d);
    async_data[(wr_cnt % D)*W +: W] = d;
    pushed.push_back(d);
    wr_cnt++;
    wr_gray = g(wr_cnt);
  endtask

  // called on a falling edge; checks the asynchronous clear before any clock edge
  task automatic do_reset();
    rst_ni  = 1'b0;
    ready   = 1'b0;
    wr_cnt  = 0;
    wr_gray = '0;
    pushed.delete();
    model_reset();
    #1;
    chk("rst_valid", W'(valid), W'(0));
    chk("rst_rd_gray", W'(rd_gray), W'(0));
    chk("rst_level", W'(level), W'(0));
    @(negedge clk);
    cycle();
    cycle();
    rst_ni = 1'b1;
  endtask

  task automatic scen_single();
    push(71'h1234);
    cycle();
    chk("s2_valid_edge_k", W'(valid), W'(0));
    cycle();
    chk("s2_valid_edge_k1", W'(valid), W'(1));
    chk("s2_data", data, 71'h1234);
    ready = 1'b1;
    cycle();
    ready = 1'b0;
    chk("s2_rd_gray_pop", W'(rd_gray), W'(2'b01));
    chk("s2_valid_pop", W'(valid), W'(0));
  endtask

  initial begin
    logic [95:0] r;
    logic [W-1:0] a;
    logic [W-1:0] b;

    // reset with random inputs, checked before the first clock edge
    rst_ni  = 1'b0;
    r       = {$urandom, $urandom, $urandom};
    ready   = r[0];
    wr_gray = r[PW:1];
    async_data = {r, r[D*W-97:0]};
    wr_cnt  = 0;
    model_reset();
    #2;
    chk("init_valid", W'(valid), W'(0));
    chk("init_rd_gray", W'(rd_gray), W'(0));
    chk("init_level", W'(level), W'(0));

    @(negedge clk);
    do_reset();
    scen_single();

    // backpressure: two entries held with ready low
    do_reset();
    a = 71'h5_0000_0000_0000_aaaa;
    b = 71'h2_1111_2222_3333_4444;
    push(a);
    cycle();
    push(b);
    repeat (10) cycle();
    chk("s3_valid", W'(valid), W'(1));
    chk("s3_data", data, a);
    chk("s3_wr_gray_drv", W'(wr_gray), W'(2'b11));
`ifdef VCSS_CDC_DST_LEVEL_EN
    chk("s3_level", W'(level), W'(2));
`else
    chk("s3_level", W'(level), W'(0));
`endif

    // reset while an entry is held, then a clean restart
    do_reset();
    scen_single();

    // wrap: eight push/pop pairs
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a = {63'h7A5A_5A5A_5A5A_5A5A, 8'(i)};
      push(a);
      cycle();
      cycle();
      chk("s4_valid", W'(valid), W'(1));
      chk("s4_data", data, a);
      chk("s4_rd_gray", W'(rd_gray), W'(gt[i % 4]));
      ready = 1'b1;
      cycle();
      ready = 1'b0;
      chk("s4_rd_gray_next", W'(rd_gray), W'(gt[(i + 1) % 4]));
    end

    // random traffic with random backpressure and one mid-stream reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      ready = 1'($urandom_range(0, 1));
      if ((wr_cnt - rd_m) < D && $urandom_range(0, 2) != 0) begin
        r = {$urandom, $urandom, $urandom};
        push(r[W-1:0]);
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
